// File: rtl/ula_src_sequencer_pkg.sv
// ---------------------------------------------------------------------------------------------
// ula_src_sequencer_pkg
// Shared definitions for the ULA operand-select sequencer: FSM state enum, ula_srcB select
// codes, ula_op codes, instruction-class codes and the per-state control decode function.
// No ports (package).
// ---------------------------------------------------------------------------------------------
package ula_src_sequencer_pkg;

    // Encodings 11..15 are unreachable and recover to StIdle.
    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExecR  = 4'd3,
        StExecI  = 4'd4,
        StAddr   = 4'd5,
        StMem    = 4'd6,
        StBranch = 4'd7,
        StWb     = 4'd8,
        StDone   = 4'd9,
        StExc    = 4'd10
    } state_e;

    // ula_srcB mux select codes
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_OFS  = 2'b10;
    localparam logic [1:0] SRCB_FOUR = 2'b11;

    // ula_srcA mux select codes
    localparam logic SRCA_PC   = 1'b0;
    localparam logic SRCA_REGA = 1'b1;

    // ula_op codes
    localparam logic [2:0] ULA_OP_ADD   = 3'b000;
    localparam logic [2:0] ULA_OP_SUB   = 3'b001;
    localparam logic [2:0] ULA_OP_FUNCT = 3'b010;

    // Instruction classes (5..7 illegal)
    localparam logic [2:0] ICLASS_R      = 3'd0;
    localparam logic [2:0] ICLASS_I      = 3'd1;
    localparam logic [2:0] ICLASS_LOAD   = 3'd2;
    localparam logic [2:0] ICLASS_STORE  = 3'd3;
    localparam logic [2:0] ICLASS_BRANCH = 3'd4;

    typedef struct packed {
        logic       ready;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] op;
        logic       pc_write;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_write;
        logic       done;
        logic       exc;
    } ctrl_t;

    // Moore control decode for a given state. The branch-taken PC write depends on the
    // live zero flag and is added outside this function.
    function automatic ctrl_t decode_ctrl(input state_e st, input logic is_load);
        ctrl_t c;
        c = '0;
        c.src_a = SRCA_PC;
        c.src_b = SRCB_REGB;
        c.op    = ULA_OP_ADD;
        case (st)
            StIdle: begin
                c.ready = 1'b1;
            end
            StFetch: begin
                c.src_b    = SRCB_FOUR;
                c.pc_write = 1'b1;
            end
            StDecode: begin
                // Branch target precompute: PC + shifted offset
                c.src_b = SRCB_OFS;
            end
            StExecR: begin
                c.src_a = SRCA_REGA;
                c.op    = ULA_OP_FUNCT;
            end
            StExecI, StAddr: begin
                c.src_a = SRCA_REGA;
                c.src_b = SRCB_IMM;
            end
            StMem: begin
                // Hold the address computation stable while memory is busy
                c.src_a  = SRCA_REGA;
                c.src_b  = SRCB_IMM;
                c.mem_rd = is_load;
                c.mem_wr = ~is_load;
            end
            StBranch: begin
                c.src_a = SRCA_REGA;
                c.op    = ULA_OP_SUB;
            end
            StWb: begin
                c.reg_write = 1'b1;
            end
            StDone: begin
                c.done = 1'b1;
            end
            StExc: begin
                c.exc = 1'b1;
            end
            default: begin
                c.ready = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ula_src_sequencer_mem_wait_counter.sv
// ---------------------------------------------------------------------------------------------
// ula_src_sequencer_mem_wait_counter
// 4-bit load/decrement counter timing the MEM state; reports when it has reached zero.
// Ports:
//   i_clk       in  1  system clock, rising edge
//   i_reset     in  1  asynchronous, active-high
//   i_load      in  1  load i_load_val (has priority over decrement)
//   i_load_val  in  4  value to load
//   i_dec       in  1  decrement by one
//   o_zero      out 1  count is zero
// ---------------------------------------------------------------------------------------------
module ula_src_sequencer_mem_wait_counter (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/ula_src_sequencer.sv
// ---------------------------------------------------------------------------------------------
// ula_src_sequencer
// Multicycle sequencer for the ULA operand muxes. Steps one instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives ula_srcA/ula_srcB/ula_op plus datapath strobes.
// Optional feature macro: ULA_OVF_TRAP_EN -- when defined, ULA overflow during EXEC_R/EXEC_I
// diverts to the exception state instead of write-back.
// Parameters:
//   MEM_WAIT      cycles spent in MEM before read data is valid (1..15)
// Ports:
//   i_clk         in  1  system clock, rising edge
//   i_reset       in  1  asynchronous, active-high
//   i_start       in  1  run one instruction; accepted only when o_ready=1
//   o_ready       out 1  sequencer idle
//   i_iclass      in  3  instruction class, sampled in DECODE
//   i_ula_zero    in  1  ULA zero flag, used in BRANCH
//   i_ula_ovf     in  1  ULA overflow flag, used in EXEC_R/EXEC_I
//   o_ula_srcA    out 1  0 PC, 1 register A
//   o_ula_srcB    out 2  00 reg B, 01 imm, 10 shifted offset, 11 constant 4
//   o_ula_op      out 3  000 ADD, 001 SUB, 010 funct-decoded
//   o_pc_write    out 1  PC load strobe
//   o_mem_rd      out 1  memory read strobe (whole MEM state, loads)
//   o_mem_wr      out 1  memory write strobe (whole MEM state, stores)
//   o_reg_write   out 1  register-file write strobe
//   o_done        out 1  one-cycle pulse at end of instruction
//   o_exc         out 1  one-cycle pulse on illegal class / overflow trap
// ---------------------------------------------------------------------------------------------
module ula_src_sequencer
    import ula_src_sequencer_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    output logic       o_ready,
    input  logic [2:0] i_iclass,
    input  logic       i_ula_zero,
    input  logic       i_ula_ovf,
    output logic       o_ula_srcA,
    output logic [1:0] o_ula_srcB,
    output logic [2:0] o_ula_op,
    output logic       o_pc_write,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_reg_write,
    output logic       o_done,
    output logic       o_exc
);

    localparam logic [3:0] MemWaitLoad = 4'(MEM_WAIT - 1);

    state_e r_state;
    logic   r_is_load;
    ctrl_t  r_ctrl;

    state_e w_state_nxt;
    logic   w_is_load_nxt;
    logic   w_cnt_zero;
    logic   w_cnt_load;
    logic   w_cnt_dec;

    ula_src_sequencer_mem_wait_counter u_mem_wait_counter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (MemWaitLoad),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Counter is primed while computing the address, so the first MEM cycle sees MEM_WAIT-1.
    assign w_cnt_load = (r_state == StAddr);
    assign w_cnt_dec  = (r_state == StMem) && !w_cnt_zero;

`ifndef ULA_OVF_TRAP_EN
    logic w_unused_ovf;
    assign w_unused_ovf = i_ula_ovf;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_is_load_nxt = r_is_load;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StFetch;
                end
            end
            StFetch: begin
                w_state_nxt = StDecode;
            end
            StDecode: begin
                case (i_iclass)
                    ICLASS_R:      w_state_nxt = StExecR;
                    ICLASS_I:      w_state_nxt = StExecI;
                    ICLASS_LOAD: begin
                        w_state_nxt   = StAddr;
                        w_is_load_nxt = 1'b1;
                    end
                    ICLASS_STORE: begin
                        w_state_nxt   = StAddr;
                        w_is_load_nxt = 1'b0;
                    end
                    ICLASS_BRANCH: w_state_nxt = StBranch;
                    default:       w_state_nxt = StExc;
                endcase
            end
            StExecR, StExecI: begin
`ifdef ULA_OVF_TRAP_EN
                w_state_nxt = i_ula_ovf ? StExc : StWb;
`else
                w_state_nxt = StWb;
`endif
            end
            StAddr: begin
                w_state_nxt = StMem;
            end
            StMem: begin
                if (w_cnt_zero) begin
                    w_state_nxt = r_is_load ? StWb : StDone;
                end
            end
            StBranch, StWb: begin
                w_state_nxt = StDone;
            end
            StDone, StExc: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state, so they align with r_state and carry no
    // combinational path from inputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_is_load <= 1'b0;
            r_ctrl    <= decode_ctrl(StIdle, 1'b0);
        end else begin
            r_state   <= w_state_nxt;
            r_is_load <= w_is_load_nxt;
            r_ctrl    <= decode_ctrl(w_state_nxt, w_is_load_nxt);
        end
    end

    assign o_ready     = r_ctrl.ready;
    assign o_ula_srcA  = r_ctrl.src_a;
    assign o_ula_srcB  = r_ctrl.src_b;
    assign o_ula_op    = r_ctrl.op;
    // The zero flag comes from the SUB issued in BRANCH itself, so the taken-branch PC load
    // must be gated by it in the same cycle; this is the only live-input term on an output.
    assign o_pc_write  = r_ctrl.pc_write | ((r_state == StBranch) & i_ula_zero);
    assign o_mem_rd    = r_ctrl.mem_rd;
    assign o_mem_wr    = r_ctrl.mem_wr;
    assign o_reg_write = r_ctrl.reg_write;
    assign o_done      = r_ctrl.done;
    assign o_exc       = r_ctrl.exc;

endmodule

// File: tb/tb_ula_src_sequencer.sv
module tb_ula_src_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ready;
    logic [2:0] iclass;
    logic       ula_zero;
    logic       ula_ovf;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] op;
    logic       pc_write;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_write;
    logic       done;
    logic       exc;

    int n_checks = 0;
    int n_fail   = 0;

    // Bit layout: ready | srcA | srcB[1:0] | op[2:0] | pc_write rd wr reg_write done exc
    localparam logic [12:0] O_IDLE   = 13'b1_0_00_000_000000;
    localparam logic [12:0] O_FETCH  = 13'b0_0_11_000_100000;
    localparam logic [12:0] O_DECODE = 13'b0_0_10_000_000000;
    localparam logic [12:0] O_EXR    = 13'b0_1_00_010_000000;
    localparam logic [12:0] O_EXI    = 13'b0_1_01_000_000000;
    localparam logic [12:0] O_ADDR   = 13'b0_1_01_000_000000;
    localparam logic [12:0] O_BRZ    = 13'b0_1_00_001_100000;
    localparam logic [12:0] O_BRNZ   = 13'b0_1_00_001_000000;
    localparam logic [12:0] O_MEMRD  = 13'b0_0_00_000_010000;
    localparam logic [12:0] O_MEMWR  = 13'b0_0_00_000_001000;
    localparam logic [12:0] O_WB     = 13'b0_0_00_000_000100;
    localparam logic [12:0] O_DONE   = 13'b0_0_00_000_000010;
    localparam logic [12:0] O_EXC    = 13'b0_0_00_000_000001;
    localparam logic [12:0] M_ALL    = 13'b1_1_11_111_111111;
    localparam logic [12:0] M_STB    = 13'b1_0_00_000_111111;

    ula_src_sequencer #(
        .MEM_WAIT (3)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .o_ready     (ready),
        .i_iclass    (iclass),
        .i_ula_zero  (ula_zero),
        .i_ula_ovf   (ula_ovf),
        .o_ula_srcA  (src_a),
        .o_ula_srcB  (src_b),
        .o_ula_op    (op),
        .o_pc_write  (pc_write),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_reg_write (reg_write),
        .o_done      (done),
        .o_exc       (exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] exp, input logic [12:0] mask);
        logic [12:0] obs;
        obs = {ready, src_a, src_b, op, pc_write, mem_rd, mem_wr, reg_write, done, exc};
        n_checks++;
        assert ((obs & mask) === (exp & mask)) else begin
            n_fail++;
            $error("FAIL %s observed=%b required=%b (mask %b)", tag, obs & mask, exp & mask,
                   mask);
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        iclass   = 3'd0;
        ula_zero = 1'b0;
        ula_ovf  = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1 chk("reset_state", O_IDLE, M_ALL);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_no_start", O_IDLE, M_ALL);

        // R-type; start held high while busy must be ignored
        iclass = 3'd0;
        start  = 1'b1;
        step(); chk("r_fetch", O_FETCH, M_ALL);
        step(); chk("r_decode", O_DECODE, M_ALL);
        step(); chk("r_exec", O_EXR, M_ALL);
        step(); chk("r_wb", O_WB, M_STB);
        step(); chk("r_done", O_DONE, M_STB);
        start = 1'b0;
        step(); chk("r_idle", O_IDLE, M_ALL);
        step(); chk("r_idle_not_queued", O_IDLE, M_ALL);

        // Load with MEM_WAIT=3: done 8 cycles after start
        iclass = 3'd2;
        start  = 1'b1;
        step(); chk("ld_fetch", O_FETCH, M_ALL);
        start = 1'b0;
        step(); chk("ld_decode", O_DECODE, M_ALL);
        step(); chk("ld_addr", O_ADDR, M_ALL);
        step(); chk("ld_mem1", O_MEMRD, M_STB);
        step(); chk("ld_mem2", O_MEMRD, M_STB);
        step(); chk("ld_mem3", O_MEMRD, M_STB);
        step(); chk("ld_wb", O_WB, M_STB);
        step(); chk("ld_done", O_DONE, M_STB);
        step(); chk("ld_idle", O_IDLE, M_ALL);

        // Store aborted by reset mid-MEM
        iclass = 3'd3;
        start  = 1'b1;
        step(); chk("st_fetch", O_FETCH, M_ALL);
        start = 1'b0;
        step(); chk("st_decode", O_DECODE, M_ALL);
        step(); chk("st_addr", O_ADDR, M_ALL);
        step(); chk("st_mem1", O_MEMWR, M_STB);
        step(); chk("st_mem2", O_MEMWR, M_STB);
        #2 rst = 1'b1;
        #1 chk("st_async_reset", O_IDLE, M_ALL);
        @(negedge clk);
        rst = 1'b0;
        step(); chk("st_after_reset_idle", O_IDLE, M_ALL);

        // Store runs normally after the abort: done 7 cycles after start
        start = 1'b1;
        step(); chk("st2_fetch", O_FETCH, M_ALL);
        start = 1'b0;
        step(); chk("st2_decode", O_DECODE, M_ALL);
        step(); chk("st2_addr", O_ADDR, M_ALL);
        step(); chk("st2_mem1", O_MEMWR, M_STB);
        step(); chk("st2_mem2", O_MEMWR, M_STB);
        step(); chk("st2_mem3", O_MEMWR, M_STB);
        step(); chk("st2_done", O_DONE, M_STB);
        step(); chk("st2_idle", O_IDLE, M_ALL);

        // Branch taken
        iclass   = 3'd4;
        ula_zero = 1'b1;
        start    = 1'b1;
        step(); chk("brz_fetch", O_FETCH, M_ALL);
        start = 1'b0;
        step(); chk("brz_decode", O_DECODE, M_ALL);
        step(); chk("brz_branch", O_BRZ, M_ALL);
        step(); chk("brz_done", O_DONE, M_STB);
        step(); chk("brz_idle", O_IDLE, M_ALL);

        // Branch not taken
        ula_zero = 1'b0;
        start    = 1'b1;
        step(); chk("brnz_fetch", O_FETCH, M_ALL);
        start = 1'b0;
        step(); chk("brnz_decode", O_DECODE, M_ALL);
        step(); chk("brnz_branch", O_BRNZ, M_ALL);
        step(); chk("brnz_done", O_DONE, M_STB);
        step(); chk("brnz_idle", O_IDLE, M_ALL);

        // Illegal class
        iclass = 3'd6;
        start  = 1'b1;
        step(); chk("ill_fetch", O_FETCH, M_ALL);
        start = 1'b0;
        step(); chk("ill_decode", O_DECODE, M_ALL);
        step(); chk("ill_exc", O_EXC, M_STB);
        step(); chk("ill_idle", O_IDLE, M_ALL);

        // I-arith with overflow
        iclass  = 3'd1;
        ula_ovf = 1'b1;
        start   = 1'b1;
        step(); chk("ovf_fetch", O_FETCH, M_ALL);
        start = 1'b0;
        step(); chk("ovf_decode", O_DECODE, M_ALL);
        step(); chk("ovf_exec", O_EXI, M_ALL);
`ifdef ULA_OVF_TRAP_EN
        step(); chk("ovf_exc", O_EXC, M_STB);
`else
        step(); chk("ovf_wb", O_WB, M_STB);
        step(); chk("ovf_done", O_DONE, M_STB);
`endif
        ula_ovf = 1'b0;
        step(); chk("ovf_idle", O_IDLE, M_ALL);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
